// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory freezes and redirect flushes.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        redirect,
    input  logic        dmem_busy,
    output logic [2:0]  lw_hazard,
    output logic        clearIFID,
    output logic        bubble_idex,
    output logic        freeze_back,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LDSTALL = 2'd1,
        S_MEMWAIT = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_fcnt;
    logic [1:0]  w_fcnt_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic        w_redir_take;
    logic        w_hazard;
    logic        w_rt_used;
    logic [4:0]  w_id_rs;
    logic [4:0]  w_id_rt;
    logic [5:0]  w_id_op;
    logic        w_unused_instr_lo;

    assign w_id_op = id_instr[31:26];
    assign w_id_rs = id_instr[25:21];
    assign w_id_rt = id_instr[20:16];
    assign w_unused_instr_lo = ^id_instr[15:0];

    // rt is a source operand only for R-type, beq, bne and sw
    assign w_rt_used = (w_id_op == 6'b000000) || (w_id_op == 6'b000100) ||
                       (w_id_op == 6'b000101) || (w_id_op == 6'b101011);

    assign w_hazard = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == w_id_rs) || ((ex_rt == w_id_rt) && w_rt_used));

    always_comb begin
        lw_hazard    = 3'b111;
        clearIFID    = 1'b0;
        bubble_idex  = 1'b0;
        freeze_back  = 1'b0;
        w_state_nxt  = r_state;
        w_fcnt_nxt   = r_fcnt;
        w_pend_nxt   = r_pend;
        w_redir_take = 1'b0;
        if (!rst) begin
            lw_hazard   = 3'b000;
            clearIFID   = 1'b1;
            bubble_idex = 1'b1;
            w_state_nxt = S_RUN;
            w_fcnt_nxt  = 2'd0;
            w_pend_nxt  = 1'b0;
        end else if (dmem_busy) begin
            // a redirect arriving while frozen is remembered until memory is ready
            lw_hazard   = 3'b000;
            freeze_back = 1'b1;
            w_state_nxt = S_MEMWAIT;
            w_fcnt_nxt  = 2'd0;
            w_pend_nxt  = r_pend | redirect;
        end else if (redirect || r_pend) begin
            clearIFID    = 1'b1;
            bubble_idex  = 1'b1;
            w_redir_take = 1'b1;
            w_pend_nxt   = 1'b0;
            w_fcnt_nxt   = FLUSH_LOAD;
            w_state_nxt  = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        end else begin
            case (r_state)
                S_FLUSH: begin
                    clearIFID   = 1'b1;
                    w_fcnt_nxt  = (r_fcnt == 2'd0) ? 2'd0 : r_fcnt - 2'd1;
                    w_state_nxt = (r_fcnt <= 2'd1) ? S_RUN : S_FLUSH;
                end
                S_LDSTALL: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    if (w_hazard) begin
                        lw_hazard   = 3'b000;
                        bubble_idex = 1'b1;
                        w_state_nxt = S_LDSTALL;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_fcnt  <= 2'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // both counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!lw_hazard[0] && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_redir_take && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model predictions, a monitor pops and compares.
// Counter expectations follow HAZARD_PERF_CNT_EN when it is defined for the build.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] id_instr = 32'd0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic        redirect = 1'b0;
    logic        dmem_busy = 1'b0;
    logic [2:0]  lw_hazard;
    logic        clearIFID;
    logic        bubble_idex;
    logic        freeze_back;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .redirect(redirect), .dmem_busy(dmem_busy),
        .lw_hazard(lw_hazard), .clearIFID(clearIFID), .bubble_idex(bubble_idex),
        .freeze_back(freeze_back), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  lw;
        logic        clr;
        logic        bub;
        logic        frz;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // reference state: plain integers describing what remains to be done
    int flush_left = 0;
    bit stall_done = 0;
    bit redir_owed = 0;
    int n_stalls = 0;
    int n_flushes = 0;

    function automatic bit load_use(input logic [31:0] ins, input logic mr, input logic [4:0] rt);
        int op;
        int src1;
        int src2;
        op   = int'(ins[31:26]);
        src1 = int'(ins[25:21]);
        src2 = int'(ins[20:16]);
        if (!mr || rt == 0) return 0;
        if (int'(rt) == src1) return 1;
        if (int'(rt) == src2 && (op == 0 || op == 4 || op == 5 || op == 43)) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] mk(input int op, input int rs, input int rt);
        logic [31:0] v;
        v = {op[5:0], rs[4:0], rt[4:0], 16'h1234};
        return v;
    endfunction

    task automatic step(input logic r, input logic mr, input logic [4:0] rt,
                        input logic [31:0] ins, input logic rd, input logic busy);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ex_mem_read = mr; ex_rt = rt; id_instr = ins; redirect = rd; dmem_busy = busy;
`ifdef HAZARD_PERF_CNT_EN
        e.sc = 16'(n_stalls);
        e.fc = 16'(n_flushes);
`else
        e.sc = 16'd0;
        e.fc = 16'd0;
`endif
        e.lw = 3'b111; e.clr = 0; e.bub = 0; e.frz = 0;
        if (!r) begin
            e.lw = 3'b000; e.clr = 1; e.bub = 1;
            flush_left = 0; stall_done = 0; redir_owed = 0; n_stalls = 0; n_flushes = 0;
        end else if (busy) begin
            e.lw = 3'b000; e.frz = 1;
            redir_owed = redir_owed || rd;
            flush_left = 0; stall_done = 0;
            if (n_stalls < 65535) n_stalls++;
        end else if (rd || redir_owed) begin
            e.clr = 1; e.bub = 1;
            redir_owed = 0; stall_done = 0;
            flush_left = FC - 1;
            if (n_flushes < 65535) n_flushes++;
        end else if (flush_left > 0) begin
            e.clr = 1;
            flush_left--;
        end else if (stall_done) begin
            stall_done = 0;
        end else if (load_use(ins, mr, rt)) begin
            e.lw = 3'b000; e.bub = 1;
            stall_done = 1;
            if (n_stalls < 65535) n_stalls++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 5'd0, 32'd0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (lw_hazard !== e.lw || clearIFID !== e.clr || bubble_idex !== e.bub ||
                    freeze_back !== e.frz || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got lw=%b clr=%b bub=%b frz=%b sc=%0d fc=%0d want lw=%b clr=%b bub=%b frz=%b sc=%0d fc=%0d",
                             cyc, lw_hazard, clearIFID, bubble_idex, freeze_back, stall_cnt, flush_cnt,
                             e.lw, e.clr, e.bub, e.frz, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] ins;
        int          opsel[6];
        int          waited;
        opsel = '{0, 4, 5, 43, 8, 35};

        repeat (3) step(0, 0, 5'd0, 32'd0, 0, 0);
        idle(2);

        // load-use on rs of an add
        step(1, 1, 5'd8, mk(0, 8, 9), 0, 0);
        step(1, 1, 5'd8, mk(0, 8, 9), 0, 0);
        idle(2);

        // r0 never stalls; addi does not read rt
        step(1, 1, 5'd0, mk(0, 0, 0), 0, 0);
        step(1, 1, 5'd8, mk(8, 3, 8), 0, 0);
        step(1, 1, 5'd8, mk(43, 3, 8), 0, 0);
        idle(2);

        // single redirect pulse
        step(1, 0, 5'd0, 32'd0, 1, 0);
        idle(3);

        // memory wait over a load-use hazard
        repeat (3) step(1, 1, 5'd8, mk(0, 8, 9), 0, 1);
        step(1, 1, 5'd8, mk(0, 8, 9), 0, 0);
        step(1, 1, 5'd8, mk(0, 8, 9), 0, 0);
        idle(2);

        // redirect arriving together with a memory wait
        step(1, 0, 5'd0, 32'd0, 1, 1);
        repeat (2) step(1, 0, 5'd0, 32'd0, 0, 1);
        idle(3);

        // load-use during flush is ignored; redirect during flush reloads
        step(1, 0, 5'd0, 32'd0, 1, 0);
        step(1, 1, 5'd5, mk(0, 5, 1), 0, 0);
        step(1, 0, 5'd0, 32'd0, 1, 0);
        step(1, 0, 5'd0, 32'd0, 0, 0);
        idle(2);

        // reset in the middle of a flush
        step(1, 0, 5'd0, 32'd0, 1, 0);
        step(0, 0, 5'd0, 32'd0, 0, 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            ins = mk(opsel[$urandom_range(0, 5)], $urandom_range(0, 7), $urandom_range(0, 7));
            step(($urandom_range(0, 40) != 0), $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                 ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(2);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
